// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and any model of the memory it fills.
// Holds the FSM encoding, the word geometry and the byte-lane order.
package imem_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  // 1: lane 0 (lowest address) carries word[31:24], so a big-endian fetch returns the word unchanged.
  localparam bit LANE_MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_WRITE     = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERR       = 3'd4
  } state_t;

endpackage

// File: rtl/word_byte_splitter.sv
// Loads a 32-bit word and shifts it out one byte per cycle in package lane order.
// byte_out always shows the byte for the current idx.
module word_byte_splitter
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        shift,
  output logic [7:0]  byte_out,
  output logic [1:0]  idx
);

  logic [31:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= word;
      idx <= '0;
    end else if (shift) begin
      sr  <= LANE_MSB_FIRST ? {sr[23:0], 8'h00} : {8'h00, sr[31:8]};
      idx <= idx + 2'd1;
    end
  end

  assign byte_out = LANE_MSB_FIRST ? sr[31:24] : sr[7:0];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words over a valid/ready port and writes
// them as four big-endian byte writes starting at BASE_ADDR, holding the core meanwhile.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  // Handshake: a word transfers on a rising edge where word_valid and word_ready are both 1.
  // word_ready is registered and is 1 exactly while the FSM sits in ST_WAIT_WORD.

  state_t      state;
  logic [31:0] addr_cnt;
  logic        last_q;
  logic [1:0]  idx;
  logic        accept;
  logic        fits;
  logic        last_byte;
  logic [32:0] end_addr;

  assign accept    = word_valid && word_ready;
  // 33-bit sum so a counter near 2^32 cannot wrap into an apparently valid range.
  assign end_addr  = {1'b0, addr_cnt} + 33'(BYTES_PER_WORD - 1);
  assign fits      = end_addr < 33'(MEM_BYTES);
  assign last_byte = (idx == 2'(BYTES_PER_WORD - 1));

  word_byte_splitter u_split (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && fits),
    .word     (word_data),
    .shift    ((state == ST_WRITE) && !last_byte),
    .byte_out (mem_wdata),
    .idx      (idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      addr_cnt   <= BASE_ADDR;
      last_q     <= 1'b0;
      word_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      core_hold  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_WAIT_WORD;
            addr_cnt   <= BASE_ADDR;
            done       <= 1'b0;
            err        <= 1'b0;
            word_ready <= 1'b1;
            core_hold  <= 1'b1;
          end
        end
        ST_WAIT_WORD: begin
          if (accept) begin
            word_ready <= 1'b0;
            if (fits) begin
              state    <= ST_WRITE;
              last_q   <= word_last;
              mem_we   <= 1'b1;
              mem_addr <= addr_cnt;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (last_byte) begin
            mem_we   <= 1'b0;
            addr_cnt <= addr_cnt + 32'(BYTES_PER_WORD);
            if (last_q) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state      <= ST_WAIT_WORD;
              word_ready <= 1'b1;
            end
          end else begin
            mem_addr <= mem_addr + 32'd1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          word_ready <= 1'b0;
          mem_we     <= 1'b0;
          core_hold  <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: three instances (default, MEM_BYTES=8, BASE_ADDR near 2^32)
// share one stimulus set; each scenario resets first so the instances start aligned.
module tb_imem_loader;
  import imem_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;

  logic        word_ready0, mem_we0, core_hold0, done0, err0;
  logic [31:0] mem_addr0;
  logic [7:0]  mem_wdata0;
  logic        word_ready1, mem_we1, core_hold1, done1, err1;
  logic [31:0] mem_addr1;
  logic [7:0]  mem_wdata1;
  logic        word_ready2, mem_we2, core_hold2, done2, err2;
  logic [31:0] mem_addr2;
  logic [7:0]  mem_wdata2;

  int checks;
  int errors;
  logic [39:0] exp_q[$];
  logic [7:0]  mem0 [0:2047];

  imem_loader #(.MEM_BYTES(2048), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid), .word_data(word_data),
    .word_last(word_last), .word_ready(word_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .core_hold(core_hold0), .done(done0), .err(err0));

  imem_loader #(.MEM_BYTES(8), .BASE_ADDR(32'h0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid), .word_data(word_data),
    .word_last(word_last), .word_ready(word_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .core_hold(core_hold1), .done(done1), .err(err1));

  imem_loader #(.MEM_BYTES(2048), .BASE_ADDR(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid), .word_data(word_data),
    .word_last(word_last), .word_ready(word_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .core_hold(core_hold2), .done(done2), .err(err2));

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte-addressed memory behind dut0
  always @(posedge clk) begin
    if (mem_we0 && mem_addr0 < 32'd2048) mem0[mem_addr0[10:0]] <= mem_wdata0;
  end

  function automatic logic [31:0] fetch(input int pc);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) w = {w[23:0], mem0[pc + i]};
    return w;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents a word and returns just after the edge that transfers it.
  task automatic accept_word(input logic [31:0] data, input logic last);
    int n;
    word_valid = 1'b1;
    word_data  = data;
    word_last  = last;
    n = 0;
    while (!word_ready0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout: word_ready=%b after %0d cycles, required 1", word_ready0, n);
    end
    tick();
    word_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if ({word_ready0, mem_we0, mem_addr0, mem_wdata0, core_hold0, done0, err0} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {word_ready0, mem_we0, mem_addr0, mem_wdata0, core_hold0, done0, err0});
    end
    tick();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({word_ready0, core_hold0, mem_we0} !== 3'b000) begin
      errors++;
      $display("FAIL release_no_session: ready/hold/we got %b required 000",
               {word_ready0, core_hold0, mem_we0});
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes [8] = '{8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h01, 8'h13};
    logic [39:0] exp;
    do_reset();
    pulse_start();
    checks++;
    if ({word_ready0, core_hold0, done0} !== 3'b110) begin
      errors++;
      $display("FAIL start_state: ready/hold/done got %b required 110", {word_ready0, core_hold0, done0});
    end
    for (int i = 0; i < 8; i++) exp_q.push_back({32'(i), bytes[i]});
    for (int w = 0; w < 2; w++) begin
      accept_word(w == 0 ? 32'h00500093 : 32'h00A00113, w == 1);
      for (int b = 0; b < 4; b++) begin
        exp = exp_q.pop_front();
        checks++;
        if (mem_we0 !== 1'b1 || {mem_addr0, mem_wdata0} !== exp) begin
          errors++;
          $display("FAIL basic_write%0d: we=%b addr/data %h required 1 %h", w * 4 + b, mem_we0,
                   {mem_addr0, mem_wdata0}, exp);
        end
        tick();
      end
    end
    checks++;
    if ({done0, core_hold0, word_ready0, mem_we0, err0} !== 5'b10000) begin
      errors++;
      $display("FAIL basic_done: done/hold/ready/we/err got %b required 10000",
               {done0, core_hold0, word_ready0, mem_we0, err0});
    end
    checks++;
    if (fetch(4) !== 32'h00A00113) begin
      errors++;
      $display("FAIL fetch_pc4: got %h required 00a00113", fetch(4));
    end
    checks++;
    if (fetch(0) !== 32'h00500093) begin
      errors++;
      $display("FAIL fetch_pc0: got %h required 00500093", fetch(0));
    end
  endtask

  task automatic test_back_to_back();
    int we_count;
    do_reset();
    pulse_start();
    word_valid = 1'b1;
    word_data  = 32'h12345678;
    word_last  = 1'b0;
    we_count   = 0;
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (word_ready0 !== (k % 5 == 0) || mem_we0 !== (k % 5 != 0)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: ready/we got %b%b required %b%b", k, word_ready0, mem_we0,
                 k % 5 == 0, k % 5 != 0);
      end
      if (mem_we0 === 1'b1) we_count++;
      tick();
    end
    word_valid = 1'b0;
    checks++;
    if (we_count != 12) begin
      errors++;
      $display("FAIL b2b_we_count: got %0d required 12", we_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    pulse_start();
    for (int w = 0; w < 2; w++) begin
      accept_word(32'h11111111 * (w + 1), 1'b0);
      checks++;
      if (mem_we1 !== 1'b1 || mem_addr1 !== 32'(w * 4)) begin
        errors++;
        $display("FAIL ovf_word%0d: we=%b addr=%h required 1 %h", w, mem_we1, mem_addr1, 32'(w * 4));
      end
      repeat (4) tick();
    end
    accept_word(32'h33333333, 1'b0);
    checks++;
    if ({err1, core_hold1, word_ready1, mem_we1, done1} !== 5'b11000) begin
      errors++;
      $display("FAIL ovf_err: err/hold/ready/we/done got %b required 11000",
               {err1, core_hold1, word_ready1, mem_we1, done1});
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_we1 !== 1'b0 || err1 !== 1'b1) begin
        errors++;
        $display("FAIL ovf_no_write%0d: we=%b err=%b required 0 1", k, mem_we1, err1);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    pulse_start();
    accept_word(32'hCAFEBABE, 1'b0);
    tick();
    checks++;
    if ({mem_we0, mem_addr0, mem_wdata0} !== {1'b1, 32'd1, 8'hFE}) begin
      errors++;
      $display("FAIL midwr_byte1: got %h required 1_00000001_fe", {mem_we0, mem_addr0, mem_wdata0});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({word_ready0, mem_we0, mem_addr0, mem_wdata0, core_hold0, done0, err0} !== 45'd0) begin
      errors++;
      $display("FAIL midwr_reset_outputs: got %h required 0",
               {word_ready0, mem_we0, mem_addr0, mem_wdata0, core_hold0, done0, err0});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({word_ready0, core_hold0, mem_we0} !== 3'b000) begin
      errors++;
      $display("FAIL midwr_idle: ready/hold/we got %b required 000", {word_ready0, core_hold0, mem_we0});
    end
    pulse_start();
    accept_word(32'h0BADF00D, 1'b1);
    checks++;
    if (mem0[0] !== 8'hCA) begin
      errors++;
      $display("FAIL midwr_kept_byte0: got %h required ca", mem0[0]);
    end
    checks++;
    if ({mem_we0, mem_addr0, mem_wdata0} !== {1'b1, 32'd0, 8'h0B}) begin
      errors++;
      $display("FAIL midwr_reload: got %h required 1_00000000_0b", {mem_we0, mem_addr0, mem_wdata0});
    end
    repeat (5) tick();
  endtask

  task automatic test_start_ignored();
    logic [7:0] bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_reset();
    pulse_start();
    accept_word(32'hDEADBEEF, 1'b1);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({mem_we0, mem_addr0, mem_wdata0} !== {1'b1, 32'(b), bytes[b]}) begin
        errors++;
        $display("FAIL start_ign_byte%0d: got %h required %h", b, {mem_we0, mem_addr0, mem_wdata0},
                 {1'b1, 32'(b), bytes[b]});
      end
      start = (b == 1);
      tick();
      start = 1'b0;
    end
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL start_ign_done: got %b required 1", done0);
    end
    pulse_start();
    checks++;
    if ({done0, err0, word_ready0, core_hold0} !== 4'b0011) begin
      errors++;
      $display("FAIL restart_state: done/err/ready/hold got %b required 0011",
               {done0, err0, word_ready0, core_hold0});
    end
    accept_word(32'h01020304, 1'b1);
    checks++;
    if ({mem_we0, mem_addr0, mem_wdata0} !== {1'b1, 32'd0, 8'h01}) begin
      errors++;
      $display("FAIL restart_base: got %h required 1_00000000_01", {mem_we0, mem_addr0, mem_wdata0});
    end
    repeat (5) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    pulse_start();
    accept_word(32'hAABBCCDD, 1'b0);
    checks++;
    if ({err2, core_hold2, mem_we2, word_ready2} !== 4'b1100) begin
      errors++;
      $display("FAIL wrap_err: err/hold/we/ready got %b required 1100",
               {err2, core_hold2, mem_we2, word_ready2});
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_we2 !== 1'b0) begin
        errors++;
        $display("FAIL wrap_no_write%0d: we=%b required 0", k, mem_we2);
      end
      tick();
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    word_last  = 1'b0;
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_overflow();
    test_reset_mid_write();
    test_start_ignored();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 2048, meaning the size of the byte-addressed instruction memory written.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, meaning the first byte address written after start.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a load session.
REQ-006 SHALL have port word_valid, input, 1: word_data is valid this cycle.
REQ-007 SHALL have port word_data, input, 32: instruction word to store.
REQ-008 SHALL have port word_last, input, 1: qualifies the final word of the session.
REQ-009 SHALL have port word_ready, output, 1: loader accepts word_data this cycle.
REQ-010 SHALL have port mem_we, output, 1: byte write strobe to instruction memory.
REQ-011 SHALL have port mem_addr, output, 32: byte address for the write.
REQ-012 SHALL have port mem_wdata, output, 8: byte to write.
REQ-013 SHALL have port core_hold, output, 1: keeps the fetch path stalled while loading.
REQ-014 SHALL have port done, output, 1: sticky load-complete flag.
REQ-015 SHALL have port err, output, 1: sticky overflow flag.

Function
REQ-016 SHALL implement states IDLE, WAIT_WORD, WRITE, DONE, ERR.
REQ-017 IDLE: start=1 -> WAIT_WORD, address counter <= BASE_ADDR, done/err cleared.
REQ-018 start SHALL be ignored in WAIT_WORD and WRITE; in DONE/ERR it restarts exactly as from IDLE.
REQ-019 word_ready SHALL be 1 only in WAIT_WORD; a word is accepted when word_valid and word_ready are both 1.
REQ-020 On acceptance with addr+3 <= MEM_BYTES-1: latch word and word_last, -> WRITE, byte index 0.
REQ-021 On acceptance with addr+3 > MEM_BYTES-1: discard word, no write, -> ERR; err=1.
REQ-022 WRITE SHALL assert mem_we for exactly 4 consecutive cycles, starting the cycle after acceptance.
REQ-023 Byte order big-endian: index 0..3 drives word[31:24], [23:16], [15:8], [7:0] at addr, addr+1, addr+2, addr+3, so a fetch of {Mem[PC],Mem[PC+1],Mem[PC+2],Mem[PC+3]} returns the word unchanged.
REQ-024 After index 3: address counter += 4; -> DONE if latched word_last, else -> WAIT_WORD.
REQ-025 Throughput SHALL be one word per 5 cycles (1 accept + 4 write).
REQ-026 mem_we SHALL be 0 in all states other than WRITE; mem_addr/mem_wdata are don't-care when mem_we=0 but SHALL NOT be X.
REQ-027 core_hold SHALL be 1 in WAIT_WORD, WRITE and ERR; 0 in IDLE and DONE.
REQ-028 done SHALL be 1 in DONE only; err SHALL be 1 in ERR only.
REQ-029 Address arithmetic SHALL be 32-bit unsigned; the overflow check SHALL not wrap (compare using a 33-bit sum).

Reset
REQ-030 rst=0 SHALL immediately force IDLE, counter=BASE_ADDR, byte index=0, and all outputs 0 (word_ready, mem_we, mem_addr, mem_wdata, core_hold, done, err).
REQ-031 Reset mid-WRITE SHALL abort the word; the bytes already written are not rolled back.
REQ-032 Release of rst SHALL not start a session; start is required.

Structure
REQ-033 State encoding, BYTES_PER_WORD=4 and the byte-lane order SHALL live in shared package imem_pkg, also used by the memory model.
REQ-034 One sub-module SHALL be used: word_byte_splitter (32-bit load, MSB-first 8-bit shift-out, 2-bit index).

Verification
REQ-035 start; words 32'h00500093, 32'h00A00113 (last) -> writes 00,50,00,93 at 0..3, then 00,A0,01,13 at 4..7; done=1; reading PC=4 returns 32'h00A00113.
REQ-036 word_valid held 1 continuously -> word_ready pulses every 5th cycle; mem_we high on exactly 4 of each 5 cycles.
REQ-037 MEM_BYTES=8, 3 words -> third word discarded, no mem_we, err=1, core_hold=1.
REQ-038 rst=0 on 2nd byte of a word -> all outputs 0 the same cycle; IDLE after release; a new start reloads from BASE_ADDR.
REQ-039 start during WRITE -> ignored, byte sequence unchanged; start in DONE -> done=0, counter=BASE_ADDR.
REQ-040 BASE_ADDR=32'hFFFF_FFFC, MEM_BYTES=2048 -> first word gives err=1 with no wrap-around write.
